// File: rtl/vx_tcu_fedp_scale_seq.sv
// Scale-factor sequencer for the TCU FEDP datapath. It buffers E8M0 (sf_a, sf_b) block
// scale pairs in a ring and presents the head pair with each issue, retiring it after BLK_STEPS issues.
module vx_tcu_fedp_scale_seq #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned BLK_STEPS = 4,
  parameter int unsigned SF_W      = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            scale_en,
  input  logic            flush,
  input  logic            sf_valid_in,
  input  logic [SF_W-1:0] sf_a_in,
  input  logic [SF_W-1:0] sf_b_in,
  output logic            sf_ready_out,
  input  logic            issue_valid,
  output logic            issue_ready,
  output logic [SF_W-1:0] sf_a,
  output logic [SF_W-1:0] sf_b,
  output logic            blk_last
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned STEP_W = (BLK_STEPS > 1) ? $clog2(BLK_STEPS) : 1;

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(BLK_STEPS - 1);
  // E8M0 encoding of 2^0 is the exponent bias.
  localparam logic [SF_W-1:0]   SF_ONE    = SF_W'((1 << (SF_W - 1)) - 1);

  logic [SF_W-1:0]   ring_a [DEPTH];
  logic [SF_W-1:0]   ring_b [DEPTH];

  logic [PTR_W-1:0]  rd_ptr, rd_ptr_n;
  logic [PTR_W-1:0]  wr_ptr, wr_ptr_n;
  logic [CNT_W-1:0]  count,  count_n;
  logic [STEP_W-1:0] step,   step_n;

  logic head_valid, step_last, push, fire, advance, pop;

  // Handshakes and head presentation, all off registered state (zero latency to fire)
  always_comb begin
    head_valid   = (count != '0);
    step_last    = (step == STEP_LAST);
    sf_ready_out = (count < CNT_FULL);
    issue_ready  = !scale_en || head_valid;
    push         = sf_valid_in && sf_ready_out;
    fire         = issue_valid && issue_ready;
    advance      = fire && scale_en;
    pop          = advance && step_last;

    sf_a     = SF_ONE;
    sf_b     = SF_ONE;
    blk_last = 1'b0;
    if (scale_en && head_valid) begin
      sf_a     = ring_a[rd_ptr];
      sf_b     = ring_b[rd_ptr];
      blk_last = step_last;
    end
  end

  // Next-state for pointers, occupancy and block step; flush wins over push/pop
  always_comb begin
    rd_ptr_n = rd_ptr;
    wr_ptr_n = wr_ptr;
    count_n  = count;
    step_n   = step;

    if (flush) begin
      rd_ptr_n = '0;
      wr_ptr_n = '0;
      count_n  = '0;
      step_n   = '0;
    end else begin
      if (push) wr_ptr_n = wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr_n = rd_ptr + PTR_W'(1);
      if (push && !pop)      count_n = count + CNT_W'(1);
      else if (pop && !push) count_n = count - CNT_W'(1);
      if (advance) step_n = step_last ? '0 : step + STEP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      step   <= '0;
    end else begin
      rd_ptr <= rd_ptr_n;
      wr_ptr <= wr_ptr_n;
      count  <= count_n;
      step   <= step_n;
    end
  end

  // Ring storage carries no reset; occupancy alone qualifies its contents
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) begin
      ring_a[wr_ptr] <= sf_a_in;
      ring_b[wr_ptr] <= sf_b_in;
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (reset) count <= CNT_FULL);
  a_no_empty_fire: assert property (@(posedge clk) disable iff (reset)
    !(issue_valid && issue_ready && scale_en && count == '0));

endmodule
